// File: rtl/al_apb_arb_pkg.sv
// Shared types and constants for the two-requester APB arbiter.
package al_apb_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    localparam int unsigned WCNT_W = 16;
    localparam int unsigned DATA_W = 32;

endpackage

// File: rtl/al_apb_arb2_if.sv
// Bus bundle for the arbiter: two upstream APB requesters, one downstream APB port, status.
interface al_apb_arb2_if
    import al_apb_arb_pkg::*;
#(
    parameter int unsigned ADDR = 20
);
    logic              m0_sel;
    logic              m0_enable;
    logic              m0_write;
    logic [ADDR-1:0]   m0_addr;
    logic [DATA_W-1:0] m0_wdata;
    logic [DATA_W-1:0] m0_rdata;
    logic              m0_ready;
    logic              m0_slverr;

    logic              m1_sel;
    logic              m1_enable;
    logic              m1_write;
    logic [ADDR-1:0]   m1_addr;
    logic [DATA_W-1:0] m1_wdata;
    logic [DATA_W-1:0] m1_rdata;
    logic              m1_ready;
    logic              m1_slverr;

    logic              s_sel;
    logic              s_enable;
    logic              s_write;
    logic [ADDR-1:0]   s_addr;
    logic [DATA_W-1:0] s_wdata;
    logic [DATA_W-1:0] s_rdata;
    logic              s_ready;
    logic              s_slverr;

    logic              busy;
    logic              grant;

    // Arbiter view: drives the downstream bus and the upstream responses.
    modport master (
        input  m0_sel, m0_enable, m0_write, m0_addr, m0_wdata,
        output m0_rdata, m0_ready, m0_slverr,
        input  m1_sel, m1_enable, m1_write, m1_addr, m1_wdata,
        output m1_rdata, m1_ready, m1_slverr,
        output s_sel, s_enable, s_write, s_addr, s_wdata,
        input  s_rdata, s_ready, s_slverr,
        output busy, grant
    );

    // Environment view: requesters, downstream completer and status observer.
    modport slave (
        output m0_sel, m0_enable, m0_write, m0_addr, m0_wdata,
        input  m0_rdata, m0_ready, m0_slverr,
        output m1_sel, m1_enable, m1_write, m1_addr, m1_wdata,
        input  m1_rdata, m1_ready, m1_slverr,
        input  s_sel, s_enable, s_write, s_addr, s_wdata,
        output s_rdata, s_ready, s_slverr,
        input  busy, grant
    );

endinterface

// File: rtl/al_apb_arb2.sv
// Two-way round-robin APB arbiter: forwards one upstream transfer at a time to a single
// downstream APB completer, with an optional downstream wait limit.
module al_apb_arb2
    import al_apb_arb_pkg::*;
#(
    parameter int unsigned ADDR    = 20,
    parameter int unsigned TIMEOUT = 0
) (
    input  logic          clk,
    input  logic          rstn,
    al_apb_arb2_if.master bus
);

    state_t            state;
    logic              last;
    logic [WCNT_W-1:0] wait_cnt;

    logic              req_any;
    logic              win;
    logic [ADDR-1:0]   win_addr;
    logic              win_write;
    logic [DATA_W-1:0] win_wdata;

    logic              done_ok;
    logic              to_hit;
    logic              done;
    logic              rdy0;
    logic              rdy1;

    // Upstream enables carry no arbitration meaning; only sel is a request.
    logic              unused_enables;
    assign unused_enables = bus.m0_enable ^ bus.m1_enable;

    // Round-robin pick: on a tie the requester not served last wins.
    always_comb begin
        req_any   = bus.m0_sel | bus.m1_sel;
        win       = (bus.m0_sel & bus.m1_sel) ? ~last : bus.m1_sel;
        win_addr  = win ? bus.m1_addr  : bus.m0_addr;
        win_write = win ? bus.m1_write : bus.m0_write;
        win_wdata = win ? bus.m1_wdata : bus.m0_wdata;
    end

    // Completion decode and upstream response steering.
    always_comb begin
        done_ok = (state == ST_ACCESS) && bus.s_ready;
        to_hit  = (TIMEOUT != 0) && (state == ST_ACCESS) && !bus.s_ready &&
                  (wait_cnt == WCNT_W'(TIMEOUT - 1));
        done    = done_ok | to_hit;
        rdy0    = done & ~bus.grant;
        rdy1    = done &  bus.grant;

        bus.m0_ready  = rdy0;
        bus.m0_slverr = rdy0 & (to_hit | bus.s_slverr);
        bus.m0_rdata  = (rdy0 && !to_hit) ? bus.s_rdata : '0;
        bus.m1_ready  = rdy1;
        bus.m1_slverr = rdy1 & (to_hit | bus.s_slverr);
        bus.m1_rdata  = (rdy1 && !to_hit) ? bus.s_rdata : '0;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state        <= ST_IDLE;
            last         <= 1'b1;
            wait_cnt     <= '0;
            bus.s_sel    <= 1'b0;
            bus.s_enable <= 1'b0;
            bus.s_write  <= 1'b0;
            bus.s_addr   <= '0;
            bus.s_wdata  <= '0;
            bus.busy     <= 1'b0;
            bus.grant    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_any) begin
                        state       <= ST_SETUP;
                        bus.grant   <= win;
                        bus.s_addr  <= win_addr;
                        bus.s_write <= win_write;
                        bus.s_wdata <= win_wdata;
                        bus.s_sel   <= 1'b1;
                        bus.busy    <= 1'b1;
                    end
                end
                ST_SETUP: begin
                    state        <= ST_ACCESS;
                    bus.s_enable <= 1'b1;
                    wait_cnt     <= '0;
                end
                ST_ACCESS: begin
                    // Address, direction and write data stay put until this transfer retires.
                    if (done) begin
                        state        <= ST_IDLE;
                        last         <= bus.grant;
                        bus.s_sel    <= 1'b0;
                        bus.s_enable <= 1'b0;
                        bus.busy     <= 1'b0;
                    end else begin
                        wait_cnt <= wait_cnt + WCNT_W'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/al_apb_arb2.md
AL_APB_ARB2 -- requirements
Module: al_apb_arb2

Interface
REQ-001 Parameter ADDR, 20, APB address width shared by both upstream ports and the downstream port.
REQ-002 Parameter TIMEOUT, 0, downstream wait limit in cycles; 0 disables the limit; legal range 0..65535.
REQ-003 clk  input  1  single clock; all state is updated on the rising edge.
REQ-004 rstn  input  1  reset, asynchronous assert, active-low.
REQ-005 mN_sel, mN_enable, mN_write  input  1 each  upstream APB requester N (N=0,1) select, enable and direction.
REQ-006 mN_addr  input  ADDR  upstream N address.
REQ-007 mN_wdata  input  32  upstream N write data.
REQ-008 mN_rdata  output  32  upstream N read data.
REQ-009 mN_ready, mN_slverr  output  1 each  upstream N ready and error.
REQ-010 s_sel, s_enable, s_write  output  1 each  downstream APB select, enable and direction.
REQ-011 s_addr  output  ADDR  downstream address.
REQ-012 s_wdata  output  32  downstream write data.
REQ-013 s_rdata  input  32  downstream read data.
REQ-014 s_ready, s_slverr  input  1 each  downstream ready and error.
REQ-015 busy  output  1  a transfer is in SETUP or ACCESS.
REQ-016 grant  output  1  index of the owning requester; valid while busy=1.

Function
REQ-017 The FSM SHALL have states IDLE, SETUP and ACCESS.
REQ-018 IDLE: if any mN_sel=1, select a winner, register its addr, write and wdata onto s_*, then go to SETUP; otherwise remain in IDLE.
REQ-019 Arbitration SHALL be two-way round-robin: with both requesting, the winner is the requester not served last; with one requesting, that requester wins.
REQ-020 SETUP: s_sel=1, s_enable=0; unconditional transition to ACCESS; wait counter cleared.
REQ-021 ACCESS: s_sel=1, s_enable=1; on s_ready=1, go to IDLE and record grant as last-served.
REQ-022 mN_ready SHALL equal (state==ACCESS && grant==N && s_ready), or the timeout completion of REQ-025.
REQ-023 mN_rdata and mN_slverr SHALL pass s_rdata and s_slverr through combinationally when mN_ready=1; otherwise both are 0.
REQ-024 A non-granted requester SHALL see mN_ready=0 until it is served; its request stays pending with no loss.
REQ-025 If TIMEOUT>0 and the 16-bit wait counter reaches TIMEOUT in ACCESS without s_ready, the block SHALL assert mN_ready=1 and mN_slverr=1 to the owner for one cycle, drive mN_rdata=0, and return to IDLE.
REQ-026 Latency: request sampled in IDLE at cycle T gives SETUP at T+1 and ACCESS at T+2; earliest upstream completion is cycle T+2; one mandatory IDLE cycle separates transfers.
REQ-027 mN_enable SHALL NOT affect arbitration; mN_sel alone constitutes a request.
REQ-028 s_addr, s_write and s_wdata SHALL hold stable from SETUP through the final ACCESS cycle.
REQ-029 s_ready while in IDLE or SETUP SHALL be ignored.
REQ-030 busy=1 in SETUP and ACCESS; grant holds its value through IDLE.

Reset
REQ-031 On rstn=0, the block SHALL enter IDLE; s_sel, s_enable, s_write, s_addr, s_wdata, busy and grant are 0; last-served=1, so requester 0 wins the first tie; the wait counter is 0.
REQ-032 Reset asserted mid-transfer SHALL abort immediately with no mN_ready pulse; after rstn rises, the block restarts from IDLE.

Structure
REQ-033 Package al_apb_arb_pkg SHALL hold the FSM state enum typedef and the 16-bit wait-counter width constant.
REQ-034 No sub-module is required; round-robin selection is inline in the arbiter.

Verification
REQ-035 m0 write, addr 0x00010, wdata 0xA5A5A5A5, s_ready high in first ACCESS -> s_sel seen at T+1, s_enable at T+2; m0_ready=1 at T+2; s_wdata=0xA5A5A5A5.
REQ-036 m0 and m1 both request from reset -> m0 served first, then m1 after one IDLE cycle; the next simultaneous request after that goes to m0.
REQ-037 m1 read, s_ready low for 5 ACCESS cycles then high with s_rdata 0x12345678 and s_slverr=1 -> m1_ready pulses once; m1_rdata=0x12345678; m1_slverr=1; m0 outputs stay 0.
REQ-038 TIMEOUT=4, s_ready held low -> m0_ready=1 and m0_slverr=1 in the 4th ACCESS cycle; s_sel=0 in the following cycle.
REQ-039 rstn pulsed low during ACCESS -> s_sel, s_enable and busy drop asynchronously; no mN_ready pulse; a new m1 request after reset completes normally.
